snn_step_ctrl: RTL and testbench
================================

# snn_step_ctrl

Timestep scheduler for the spiking conv/fc inference datapath. It replaces the free-running state/address generators with one FSM that, for each of T_STEPS timesteps:
- issues the BRAM read;
- waits out the BRAM, conv/pool and fc latencies;
- writes membrane and spike state back;
- masks the stale state on the first step.

It also accumulates fc output spikes per class and reports the winning class at the end of the run.

## Interface
Parameters:
- ADDR_W, 4, timestep address width for all state/weight BRAMs
- T_STEPS, 16, timesteps per inference, 2..2**ADDR_W
- RD_LAT, 1, BRAM read latency in cycles, ≥1
- CONV_LAT, 2, conv_act_pool latency after read data valid, ≥1
- FC_LAT, 2, fc_act_pool + act_fc latency after conv write-back, ≥1
- N_CLASS, 10, fc output neurons

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin an inference; sampled only in IDLE
- s_fc  in  N_CLASS  fc spike vector from act_fc, sampled in FCWB
- en_load  out  1  read enable for weight, input and state BRAMs
- addr_r  out  ADDR_W  read address (current timestep t)
- addr_w  out  ADDR_W  state write address, (t+1) mod 2**ADDR_W
- we_conv  out  1  write strobe for conv spike/vold BRAMs
- we_fc  out  1  write strobe for fc spike/vold BRAMs
- first_step  out  1  high for the whole of step 0; masks old state to zero
- step_valid  out  1  one-cycle pulse when out_p/out_fc of step t are valid
- busy  out  1  high from RD of step 0 through DONE
- done  out  1  one-cycle completion pulse
- class_out  out  $clog2(N_CLASS)  winning class, held until next start
- class_valid  out  1  high with done, held until next start or reset

## Operation
- States, in order: IDLE, RD, LAT, CONV, WB, FC, FCWB, ARG, DONE.
- IDLE
  - start=1 → clear t, clear spike counters and class_valid → RD.
  - start in any other state is ignored.
- RD (1 cycle): en_load=1, addr_r=t.
- LAT: RD_LAT cycles.
- CONV: CONV_LAT cycles.
- WB (1 cycle): we_conv=1 at addr_w.
- FC: FC_LAT cycles.
- FCWB (1 cycle):
  - we_fc=1, step_valid=1.
  - Add each bit of s_fc to its per-class counter.
  - If t==T_STEPS-1 → ARG; else t+1 → RD.
- Last-step write-back is suppressed: we_conv and we_fc stay 0 when t==T_STEPS-1, so address 0 is not clobbered by the wrap.
- ARG (1 cycle): class_out ← index of the maximum counter; ties resolve to the lowest index.
- DONE (1 cycle): done=1, class_valid=1 → IDLE.
- addr_r, addr_w and first_step are held stable from RD through FCWB of each step.
- Counters are CNT_W=$clog2(T_STEPS+1) bits and cannot overflow.
- A single wait counter is reused by LAT, CONV and FC; it is loaded on state entry.

## Timing
- Cycles per step: STEP_CYC = 3 + RD_LAT + CONV_LAT + FC_LAT (defaults: 8 cycles = 80 ns at 100 MHz).
- start high in cycle 0 (IDLE):
  - RD of step 0 in cycle 1;
  - done in cycle T_STEPS*STEP_CYC + 2 (130 with defaults).
- step_valid of step t in cycle (t+1)*STEP_CYC.
- Reset values:
  - state=IDLE, t=0, counters=0, class_out=0;
  - all strobes, busy, done, class_valid=0;
  - addr_r=0, addr_w=1, first_step=0.
- Reset mid-run returns to IDLE on the next edge with no further BRAM strobes. A partial run is discarded.
- Reset has priority over start in the same cycle.
- start held high through DONE → next run begins one cycle after DONE (IDLE re-samples it).

## Configuration
- SNN_STEP_CTRL_CLASSIFY_EN
  - Defined: spike counters and the ARG state are built as described.
  - Undefined:
    - no counters; s_fc is unused;
    - FCWB(last) goes directly to DONE, so done comes one cycle earlier (cycle T_STEPS*STEP_CYC+1);
    - class_out is tied to 0 and class_valid to 0.

## Structure
- Shared package snn_pkg holds:
  - the state enum;
  - N_CLASS and ADDR_W defaults;
  - the STEP_CYC function.
- One sub-module, snn_argmax: purely combinational max/index over N_CLASS counters with the lowest-index tie rule.
- The FSM, timestep counter and wait counter stay in snn_step_ctrl.

## Test plan
- Reset then start, defaults →
  - en_load pulses at cycles 1, 9, …, 121;
  - addr_r 0..15, addr_w 1..15,0;
  - done at cycle 130;
  - no we_conv/we_fc in step 15.
- first_step → high in cycles 1–8 only; step_valid at cycles 8, 16, …, 128.
- s_fc=10'b0000001000 on all steps except 10'b0000000100 on steps 0–3 → class_out=3, class_valid=1 at done.
- All-equal counts (s_fc all ones every step) → class_out=0.
- rst asserted in cycle 50 → IDLE at cycle 51; no strobes afterwards; a new start reruns the full sequence with counters cleared.
- start pulsed while busy at cycle 20 → ignored; done still at 130.
- RD_LAT=2, CONV_LAT=3, FC_LAT=1 → STEP_CYC=9; done at 146.
- Without SNN_STEP_CTRL_CLASSIFY_EN → done at 129; class_valid stays 0.

Source files
------------

// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared types, defaults and step timing helper for the snn timestep scheduler
package snn_pkg;

    localparam int N_CLASS_DEF = 10;
    localparam int ADDR_W_DEF  = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD,
        ST_LAT,
        ST_CONV,
        ST_WB,
        ST_FC,
        ST_FCWB,
        ST_ARG,
        ST_DONE
    } state_t;

    function automatic int step_cyc(input int rd_lat, input int conv_lat, input int fc_lat);
        return 3 + rd_lat + conv_lat + fc_lat;
    endfunction

endpackage

// File: rtl/snn_argmax.sv
// rtl/snn_argmax.sv - combinational argmax over per-class spike counters, ties go to the lowest index
module snn_argmax
    import snn_pkg::*;
#(
    parameter int N     = N_CLASS_DEF,
    parameter int CNT_W = 5,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0][CNT_W-1:0] cnt,
    output logic [IDX_W-1:0]        idx
);

    logic [CNT_W-1:0] best;

    // Strict greater-than keeps the earliest index on equal counts.
    always_comb begin
        idx  = '0;
        best = cnt[0];
        for (int i = 1; i < N; i++) begin
            if (cnt[i] > best) begin
                best = cnt[i];
                idx  = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/snn_step_ctrl.sv
// rtl/snn_step_ctrl.sv - timestep scheduler FSM with optional spike-count classifier
// Classifier (counters + ARG state) built only when SNN_STEP_CTRL_CLASSIFY_EN is defined.
module snn_step_ctrl
    import snn_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int T_STEPS  = 16,
    parameter int RD_LAT   = 1,
    parameter int CONV_LAT = 2,
    parameter int FC_LAT   = 2,
    parameter int N_CLASS  = N_CLASS_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [N_CLASS-1:0]         s_fc,
    output logic                       en_load,
    output logic [ADDR_W-1:0]          addr_r,
    output logic [ADDR_W-1:0]          addr_w,
    output logic                       we_conv,
    output logic                       we_fc,
    output logic                       first_step,
    output logic                       step_valid,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(N_CLASS)-1:0] class_out,
    output logic                       class_valid
);

    localparam int CLS_W   = $clog2(N_CLASS);
    localparam int MAX_LAT = (RD_LAT > CONV_LAT) ? ((RD_LAT > FC_LAT) ? RD_LAT : FC_LAT)
                                                 : ((CONV_LAT > FC_LAT) ? CONV_LAT : FC_LAT);
    localparam int WAIT_W  = $clog2(MAX_LAT + 1);
    localparam logic [ADDR_W-1:0] T_LAST = ADDR_W'(T_STEPS - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] t;
    logic [WAIT_W-1:0] wait_cnt;
    logic              last_step;
    logic              run_start;

    assign last_step = (t == T_LAST);
    assign run_start = (state == ST_IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            t        <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (run_start)
                t <= '0;
            else if (state == ST_FCWB && !last_step)
                t <= t + ADDR_W'(1);
            // One down-counter serves all three latency states, reloaded on entry.
            if (state_nxt != state) begin
                case (state_nxt)
                    ST_LAT:  wait_cnt <= WAIT_W'(RD_LAT - 1);
                    ST_CONV: wait_cnt <= WAIT_W'(CONV_LAT - 1);
                    ST_FC:   wait_cnt <= WAIT_W'(FC_LAT - 1);
                    default: wait_cnt <= wait_cnt;
                endcase
            end else if (wait_cnt != '0) begin
                wait_cnt <= wait_cnt - WAIT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RD;
            ST_RD:   state_nxt = ST_LAT;
            ST_LAT:  if (wait_cnt == '0) state_nxt = ST_CONV;
            ST_CONV: if (wait_cnt == '0) state_nxt = ST_WB;
            ST_WB:   state_nxt = ST_FC;
            ST_FC:   if (wait_cnt == '0) state_nxt = ST_FCWB;
            ST_FCWB: begin
                if (!last_step)
                    state_nxt = ST_RD;
                else begin
`ifdef SNN_STEP_CTRL_CLASSIFY_EN
                    state_nxt = ST_ARG;
`else
                    state_nxt = ST_DONE;
`endif
                end
            end
            ST_ARG:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        en_load    = (state == ST_RD);
        we_conv    = (state == ST_WB)   && !last_step;
        we_fc      = (state == ST_FCWB) && !last_step;
        step_valid = (state == ST_FCWB);
        busy       = (state != ST_IDLE);
        done       = (state == ST_DONE);
        first_step = (t == '0) && (state inside {ST_RD, ST_LAT, ST_CONV, ST_WB, ST_FC, ST_FCWB});
    end

    // The write address wraps naturally; the last step never writes it.
    assign addr_r = t;
    assign addr_w = t + ADDR_W'(1);

`ifdef SNN_STEP_CTRL_CLASSIFY_EN
    localparam int CNT_W = $clog2(T_STEPS + 1);

    logic [N_CLASS-1:0][CNT_W-1:0] cnt;
    logic [CLS_W-1:0]              win_idx;
    logic [CLS_W-1:0]              class_q;
    logic                          class_valid_q;

    snn_argmax #(
        .N     (N_CLASS),
        .CNT_W (CNT_W),
        .IDX_W (CLS_W)
    ) u_argmax (
        .cnt (cnt),
        .idx (win_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            class_q       <= '0;
            class_valid_q <= 1'b0;
        end else if (run_start) begin
            cnt           <= '0;
            class_q       <= '0;
            class_valid_q <= 1'b0;
        end else begin
            if (state == ST_FCWB) begin
                for (int k = 0; k < N_CLASS; k++)
                    cnt[k] <= cnt[k] + CNT_W'(s_fc[k]);
            end
            if (state == ST_ARG) begin
                class_q       <= win_idx;
                class_valid_q <= 1'b1;
            end
        end
    end

    assign class_out   = class_q;
    assign class_valid = class_valid_q;
`else
    logic unused_s_fc;

    assign unused_s_fc = ^s_fc;
    assign class_out   = CLS_W'(0);
    assign class_valid = 1'b0;
`endif

endmodule

// File: tb/tb_snn_step_ctrl.sv
// tb/tb_snn_step_ctrl.sv - scoreboard bench for snn_step_ctrl (default and non-default latencies)
module tb_snn_step_ctrl;
    import snn_pkg::*;

    localparam int T  = 16;
    localparam int NC = 10;
    localparam int AW = 4;
    localparam int CW = $clog2(NC);
    localparam int S  = step_cyc(1, 2, 2);
    localparam int S2 = step_cyc(2, 3, 1);
`ifdef SNN_STEP_CTRL_CLASSIFY_EN
    localparam int DONE_OFF = 2;
    localparam int CLS_EN   = 1;
`else
    localparam int DONE_OFF = 1;
    localparam int CLS_EN   = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, start2;
    logic [NC-1:0] s_fc, s_fc2;
    logic          en_load, we_conv, we_fc, first_step, step_valid, busy, done, class_valid;
    logic [AW-1:0] addr_r, addr_w;
    logic [CW-1:0] class_out;
    logic          en_load2, we_conv2, we_fc2, first_step2, step_valid2, busy2, done2, class_valid2;
    logic [AW-1:0] addr_r2, addr_w2;
    logic [CW-1:0] class_out2;

    snn_step_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .s_fc(s_fc),
        .en_load(en_load), .addr_r(addr_r), .addr_w(addr_w),
        .we_conv(we_conv), .we_fc(we_fc), .first_step(first_step),
        .step_valid(step_valid), .busy(busy), .done(done),
        .class_out(class_out), .class_valid(class_valid)
    );

    snn_step_ctrl #(.RD_LAT(2), .CONV_LAT(3), .FC_LAT(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .s_fc(s_fc2),
        .en_load(en_load2), .addr_r(addr_r2), .addr_w(addr_w2),
        .we_conv(we_conv2), .we_fc(we_fc2), .first_step(first_step2),
        .step_valid(step_valid2), .busy(busy2), .done(done2),
        .class_out(class_out2), .class_valid(class_valid2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    typedef struct {
        int cyc;
        int a;
        int b;
        int c;
    } ev_t;

    ev_t q_rd[$], q_sv[$], q_wc[$], q_wf[$], q_done[$];

    logic [NC-1:0] pat [T];
    int cur_base = 0;
    int fs_cnt   = 0;
    int done2_exp = 0;
    int done2_seen = 0;

    // s_fc follows the per-step stimulus table of the current run
    always @(posedge clk) begin
        int st;
        #1;
        st = (cyc - cur_base - 1) / S;
        if (st < 0) st = 0;
        if (st > T - 1) st = T - 1;
        s_fc = pat[st];
    end

    function automatic int exp_class();
        int cnt [NC];
        int best;
        for (int k = 0; k < NC; k++) cnt[k] = 0;
        for (int t = 0; t < T; t++)
            for (int k = 0; k < NC; k++)
                if (pat[t][k]) cnt[k]++;
        best = 0;
        for (int k = 1; k < NC; k++)
            if (cnt[k] > cnt[best]) best = k;
        return best * CLS_EN;
    endfunction

    task automatic push_run(input int base);
        ev_t e;
        for (int t = 0; t < T; t++) begin
            e.cyc = base + t * S + 1; e.a = t; e.b = (t + 1) % (1 << AW); e.c = (t == 0) ? 1 : 0;
            q_rd.push_back(e);
            e.cyc = base + (t + 1) * S; e.a = t; e.b = 0; e.c = (t == 0) ? 1 : 0;
            q_sv.push_back(e);
            if (t < T - 1) begin
                e.cyc = base + t * S + 5; e.a = (t + 1) % (1 << AW); e.b = 0; e.c = 0;
                q_wc.push_back(e);
                e.cyc = base + (t + 1) * S;
                q_wf.push_back(e);
            end
        end
        e.cyc = base + T * S + DONE_OFF; e.a = exp_class(); e.b = CLS_EN; e.c = 0;
        q_done.push_back(e);
    endtask

    task automatic flush_all();
        q_rd.delete(); q_sv.delete(); q_wc.delete(); q_wf.delete(); q_done.delete();
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (en_load) begin
            if (q_rd.size() == 0) check("rd_extra", 1, 0);
            else begin
                e = q_rd.pop_front();
                check("rd_cyc", cyc, e.cyc);
                check("addr_r", int'(addr_r), e.a);
                check("addr_w", int'(addr_w), e.b);
                check("first_rd", int'(first_step), e.c);
            end
        end
        if (step_valid) begin
            if (q_sv.size() == 0) check("sv_extra", 1, 0);
            else begin
                e = q_sv.pop_front();
                check("sv_cyc", cyc, e.cyc);
                check("sv_addr_r", int'(addr_r), e.a);
                check("first_sv", int'(first_step), e.c);
            end
        end
        if (we_conv) begin
            if (q_wc.size() == 0) check("wc_extra", 1, 0);
            else begin
                e = q_wc.pop_front();
                check("wc_cyc", cyc, e.cyc);
                check("wc_addr", int'(addr_w), e.a);
            end
        end
        if (we_fc) begin
            if (q_wf.size() == 0) check("wf_extra", 1, 0);
            else begin
                e = q_wf.pop_front();
                check("wf_cyc", cyc, e.cyc);
                check("wf_addr", int'(addr_w), e.a);
            end
        end
        if (done) begin
            if (q_done.size() == 0) check("done_extra", 1, 0);
            else begin
                e = q_done.pop_front();
                check("done_cyc", cyc, e.cyc);
                check("class_out", int'(class_out), e.a);
                check("class_valid", int'(class_valid), e.b);
            end
        end
        if (first_step) fs_cnt++;
        if (done2) begin
            done2_seen++;
            check("done2_cyc", cyc, done2_exp);
            check("class_out2", int'(class_out2), 9 * CLS_EN);
            check("class_valid2", int'(class_valid2), CLS_EN);
        end
    end

    task automatic wait_until(input int abs_cyc);
        while (cyc < abs_cyc) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_run(output int base);
        @(posedge clk);
        #1;
        base = cyc;
        cur_base = base;
        push_run(base);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (q_done.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("done_pending", q_done.size(), 0);
        check("rd_pending", q_rd.size(), 0);
        check("sv_pending", q_sv.size(), 0);
        check("wr_pending", q_wc.size() + q_wf.size(), 0);
        flush_all();
    endtask

    initial begin
        int base;
        rst = 1'b1; start = 1'b1; start2 = 1'b1;
        s_fc2 = 10'b1000000000;
        for (int t = 0; t < T; t++) pat[t] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0; start2 = 1'b0;
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_en_load", int'(en_load), 0);
        check("rst_we", int'(we_conv) + int'(we_fc), 0);
        check("rst_step_valid", int'(step_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_addr_r", int'(addr_r), 0);
        check("rst_addr_w", int'(addr_w), 1);
        check("rst_first_step", int'(first_step), 0);
        check("rst_class_out", int'(class_out), 0);
        check("rst_class_valid", int'(class_valid), 0);

        // class 3 wins 12:4, plus an ignored start pulse mid-run
        for (int t = 0; t < T; t++) pat[t] = (t < 4) ? 10'b0000000100 : 10'b0000001000;
        fs_cnt = 0;
        start_run(base);
        wait_until(base + 20);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(400);
        check("first_step_cycles", fs_cnt, S);
        repeat (5) @(negedge clk);
        check("class_valid_hold", int'(class_valid), CLS_EN);
        check("class_out_hold", int'(class_out), 3 * CLS_EN);

        // all classes tie
        for (int t = 0; t < T; t++) pat[t] = '1;
        start_run(base);
        @(negedge clk);
        check("class_valid_cleared", int'(class_valid), 0);
        wait_done(400);

        // reset in cycle 50 discards the partial run
        for (int t = 0; t < T; t++) pat[t] = 10'b0010000000;
        start_run(base);
        wait_until(base + 50);
        rst = 1'b1;
        flush_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_addr_r", int'(addr_r), 0);
        repeat (20) @(negedge clk);

        // rerun after reset: stale class-7 counts must not survive
        for (int t = 0; t < T; t++) pat[t] = (t < 9) ? 10'b0000000100 : 10'b0010000000;
        start_run(base);
        wait_done(400);

        // start held high through DONE chains a second run
        for (int t = 0; t < T; t++) pat[t] = 10'b0000100000;
        @(posedge clk);
        #1;
        base = cyc;
        cur_base = base;
        push_run(base);
        push_run(base + T * S + DONE_OFF + 1);
        start = 1'b1;
        wait_until(base + T * S + DONE_OFF + 2);
        start = 1'b0;
        wait_done(800);

        // non-default latencies on the second instance
        @(posedge clk);
        #1;
        done2_exp = cyc + T * S2 + DONE_OFF;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        for (int n = 0; n < 400 && done2_seen == 0; n++) @(posedge clk);
        #1;
        check("done2_seen", done2_seen, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
